io_bus_master: RTL

IO_BUS_MASTER -- requirements
Module: io_bus_master

---
 rtl/io_bus_pkg.sv | 28 ++
 rtl/io_req_fifo.sv | 46 ++++
 rtl/io_bus_master.sv | 114 +++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared constants and types for the IO bus master: bus widths, FSM state
// encoding and the packed request entry {write, addr, wdata}.
package io_bus_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 8;
   localparam int REQ_W      = 1 + ADDR_W + DATA_W;
   localparam int FIFO_DEPTH = 2;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WR      = 2'd1;
   localparam logic [1:0] S_RD_ADDR = 2'd2;
   localparam logic [1:0] S_RD_DATA = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = S_IDLE,
      ST_WR      = S_WR,
      ST_RD_ADDR = S_RD_ADDR,
      ST_RD_DATA = S_RD_DATA
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/io_req_fifo.sv
// Two-entry request FIFO placed in front of the bus FSM when
// IO_BUS_MASTER_QUEUE_EN is defined. Push is ignored when full, pop when empty.
module io_req_fifo
   import io_bus_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [REQ_W-1:0] wr_entry,
   input  logic             pop,
   output logic [REQ_W-1:0] rd_entry,
   output logic             empty,
   output logic             full
);

   logic [REQ_W-1:0] mem [FIFO_DEPTH];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == 2'd0);
   assign full     = (count == 2'(FIFO_DEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign rd_entry = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

endmodule

// File: rtl/io_bus_master.sv
// IO bus master: turns single read/write requests into registered bus cycles.
// Define IO_BUS_MASTER_QUEUE_EN to add a 2-entry request FIFO in front of the FSM.
module io_bus_master
   import io_bus_pkg::*;
#(
   parameter logic [ADDR_W-1:0] P_ADDR_RST_VAL = 16'h0000
)
(
   input  logic              I_CLK,
   input  logic              I_SYNC_RESET,
   inout  wire  [DATA_W-1:0] IO_DATA_BUS,
   output logic [ADDR_W-1:0] O_ADDR_BUS,
   output logic              O_WE_BUS,
   output logic              O_RE_BUS,
   input  logic              I_REQ_VALID,
   output logic              O_REQ_READY,
   input  logic              I_REQ_WRITE,
   input  logic [ADDR_W-1:0] I_REQ_ADDR,
   input  logic [DATA_W-1:0] I_REQ_WDATA,
   output logic              O_RSP_VALID,
   output logic [DATA_W-1:0] O_RSP_RDATA,
   output logic              O_RSP_WRITE,
   output logic              O_BUSY
);

   state_t            state;
   logic              drive;
   logic [DATA_W-1:0] wdata;
   logic              launch;
   req_t              req;
   req_t              in_req;

   assign in_req      = {I_REQ_WRITE, I_REQ_ADDR, I_REQ_WDATA};
   assign IO_DATA_BUS = drive ? wdata : {DATA_W{1'bz}};

`ifdef IO_BUS_MASTER_QUEUE_EN
   logic             q_empty;
   logic             q_full;
   logic [REQ_W-1:0] q_head;

   io_req_fifo u_fifo (
      .clk      (I_CLK),
      .rst      (I_SYNC_RESET),
      .push     (I_REQ_VALID && O_REQ_READY),
      .wr_entry (in_req),
      .pop      (launch),
      .rd_entry (q_head),
      .empty    (q_empty),
      .full     (q_full)
   );

   // Popping while the response pulse is out lets writes issue every 2 cycles.
   assign O_REQ_READY = !I_SYNC_RESET && !q_full;
   assign launch      = !I_SYNC_RESET && !q_empty && (state == ST_IDLE);
   assign req         = q_head;
   assign O_BUSY      = !I_SYNC_RESET && ((state != ST_IDLE) || !q_empty);
`else
   assign O_REQ_READY = !I_SYNC_RESET && (state == ST_IDLE) && !O_RSP_VALID;
   assign launch      = I_REQ_VALID && O_REQ_READY;
   assign req         = in_req;
   assign O_BUSY      = !I_SYNC_RESET && (state != ST_IDLE);
`endif

   always_ff @(posedge I_CLK) begin
      if (I_SYNC_RESET) begin
         state       <= ST_IDLE;
         O_ADDR_BUS  <= P_ADDR_RST_VAL;
         O_WE_BUS    <= 1'b0;
         O_RE_BUS    <= 1'b0;
         drive       <= 1'b0;
         O_RSP_VALID <= 1'b0;
         O_RSP_RDATA <= '0;
         O_RSP_WRITE <= 1'b0;
      end else begin
         O_WE_BUS    <= 1'b0;
         O_RE_BUS    <= 1'b0;
         drive       <= 1'b0;
         O_RSP_VALID <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  O_ADDR_BUS <= req.addr;
                  wdata      <= req.wdata;
                  if (req.write) begin
                     state    <= ST_WR;
                     O_WE_BUS <= 1'b1;
                     drive    <= 1'b1;
                  end else begin
                     state    <= ST_RD_ADDR;
                     O_RE_BUS <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               state       <= ST_IDLE;
               O_RSP_VALID <= 1'b1;
               O_RSP_WRITE <= 1'b1;
            end
            ST_RD_ADDR: begin
               state <= ST_RD_DATA;
            end
            ST_RD_DATA: begin
               // Responder drives the bus this cycle, one cycle after the strobe.
               state       <= ST_IDLE;
               O_RSP_RDATA <= IO_DATA_BUS;
               O_RSP_VALID <= 1'b1;
               O_RSP_WRITE <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
